icache_fill: RTL and testbench

- Direct-mapped instruction cache with miss-fill state machine.
- Sits between the CPU fetch path (PC to instruction) and a multi-cycle main memory.
- Replaces the single-cycle instruction memory: hits return an instruction in the same cycle; misses stall the CPU while an 8-word line is fetched.
- The CPU gates PC update with stall, the same way it already gates on halt.

---
 rtl/icache_fill.sv | 133 +++++++++++++
 tb/tb_icache_fill.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/icache_fill.sv
// rtl/icache_fill.sv - direct-mapped instruction cache with 8-word line miss-fill FSM
// Hits return in the same cycle; a miss stalls the CPU while the line is requested and collected in order.
module icache_fill #(
  parameter int NUM_LINES      = 32,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  input  logic        flush,
  output logic [15:0] instr,
  output logic        stall,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        mem_valid,
  output logic [15:0] miss_count
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int TW = 12 - IW;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [OW-1:0]   recv_cnt_q, recv_cnt_d;
  logic [11:0]     line_q, line_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [15:0]     miss_count_q, miss_count_d;

  logic [TW-1:0]   tag_ram  [NUM_LINES];
  logic [15:0]     data_ram [NUM_LINES][WORDS_PER_LINE];

  logic [IW-1:0]   req_idx;
  logic [TW-1:0]   req_tag;
  logic [OW-1:0]   req_off;
  logic [IW-1:0]   fill_idx;
  logic [TW-1:0]   fill_tag;
  logic            hit;
  logic            data_we;
  logic            commit;
  logic            unused_addr_bit;

  assign req_idx  = fetch_addr[3+IW:4];
  assign req_tag  = fetch_addr[15:4+IW];
  assign req_off  = fetch_addr[OW:1];
  assign fill_idx = line_q[IW-1:0];
  assign fill_tag = line_q[11:IW];
  assign hit      = valid_q[req_idx] && (tag_ram[req_idx] == req_tag);
  assign unused_addr_bit = fetch_addr[0];
  assign miss_count = miss_count_q;

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    line_d       = line_q;
    valid_d      = valid_q;
    miss_count_d = miss_count_q;
    instr        = 16'h0000;
    stall        = 1'b0;
    mem_en       = 1'b0;
    mem_addr     = 16'h0000;
    data_we      = 1'b0;
    commit       = 1'b0;

    case (state_q)
      IDLE: begin
        instr = hit ? data_ram[req_idx][req_off] : 16'h0000;
        // stall is forced low while reset is held even though fetch_req may be high
        stall = ((fetch_req && !hit) || flush) && !rst;
        if (flush) begin
          valid_d = '0;
        end else if (fetch_req && !hit) begin
          line_d       = fetch_addr[15:4];
          issue_cnt_d  = '0;
          recv_cnt_d   = '0;
          miss_count_d = (miss_count_q == 16'hFFFF) ? miss_count_q : miss_count_q + 16'd1;
          state_d      = FILL;
        end
      end
      FILL: begin
        stall       = 1'b1;
        mem_en      = 1'b1;
        mem_addr    = {line_q, issue_cnt_q, 1'b0};
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == OW'(WORDS_PER_LINE - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        stall = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // returns are collected in FILL and DRAIN; the last one commits the line
    if (mem_valid && (state_q != IDLE)) begin
      data_we    = 1'b1;
      recv_cnt_d = recv_cnt_q + 1'b1;
      if (recv_cnt_q == OW'(WORDS_PER_LINE - 1)) begin
        commit            = 1'b1;
        valid_d[fill_idx] = 1'b1;
        state_d           = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
      line_q       <= '0;
      valid_q      <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      line_q       <= line_d;
      valid_q      <= valid_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_ram[fill_idx][recv_cnt_q] <= mem_data;
    if (commit)  tag_ram[fill_idx] <= fill_tag;
  end

endmodule

// File: tb/tb_icache_fill.sv
// tb/tb_icache_fill.sv - randomized bench for icache_fill against a timing-level cache model
module tb_icache_fill;

  localparam int IW = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = 16'h0000;
  logic        flush = 1'b0;
  logic [15:0] instr;
  logic        stall;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data = 16'h0000;
  logic        mem_valid = 1'b0;
  logic [15:0] miss_count;

  icache_fill dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .flush      (flush),
    .instr      (instr),
    .stall      (stall),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_valid  (mem_valid),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 4;

  typedef struct packed {
    logic [31:0] due;
    logic [15:0] a;
  } ret_t;
  ret_t q[$];

  // reference: cache contents plus the arithmetic schedule of the fill in flight
  bit          rv [32];
  logic [6:0]  rt [32];
  logic [15:0] rd [32][8];
  bit          busy = 0;
  int          c0 = 0;
  logic [15:0] fbase = 16'h0000;
  logic [15:0] mcnt = 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle(input logic r, input logic req, input logic [15:0] a, input logic fl);
    logic [4:0]  idx;
    logic [6:0]  tg;
    logic [2:0]  off;
    bit          hit;
    logic        ex_stall;
    logic        ex_en;
    logic [15:0] ex_addr;
    logic [4:0]  fidx;
    @(negedge clk);
    if (mem_en === 1'b1) q.push_back('{due: 32'(cyc + lat), a: mem_addr});
    rst        = r;
    fetch_req  = req;
    fetch_addr = a;
    flush      = fl;
    mem_valid  = 1'b0;
    if (q.size() > 0 && q[0].due == 32'(cyc)) begin
      mem_valid = 1'b1;
      mem_data  = q[0].a;
      void'(q.pop_front());
    end
    #1;
    idx = a[3+IW:4];
    tg  = a[15:4+IW];
    off = a[3:1];
    if (r) begin
      busy = 0;
      mcnt = 16'h0000;
      for (int i = 0; i < 32; i++) rv[i] = 0;
      check("rst_stall", stall, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_instr", instr, 0);
      check("rst_miss_count", miss_count, 0);
    end else if (busy) begin
      ex_en   = (cyc >= c0 + 1) && (cyc <= c0 + 8);
      check("fill_stall", stall, 1);
      check("fill_mem_en", mem_en, ex_en);
      if (ex_en) begin
        ex_addr = fbase + 16'(2 * (cyc - c0 - 1));
        check("fill_mem_addr", mem_addr, ex_addr);
      end
      check("fill_miss_count", miss_count, mcnt);
      if (cyc == c0 + 8 + lat) begin
        fidx = fbase[3+IW:4];
        rv[fidx] = 1;
        rt[fidx] = fbase[15:4+IW];
        for (int k = 0; k < 8; k++) rd[fidx][k] = fbase + 16'(2 * k);
        busy = 0;
      end
    end else begin
      hit      = rv[idx] && (rt[idx] == tg);
      ex_stall = (req && !hit) || fl;
      check("idle_stall", stall, ex_stall);
      check("idle_mem_en", mem_en, 0);
      check("idle_miss_count", miss_count, mcnt);
      if (req && !ex_stall) check("hit_instr", instr, rd[idx][off]);
      if (fl) begin
        for (int i = 0; i < 32; i++) rv[i] = 0;
      end else if (req && !hit) begin
        busy  = 1;
        c0    = cyc;
        fbase = {a[15:4], 4'b0000};
        if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      end
    end
    cyc++;
  endtask

  initial begin
    logic [15:0] ra;
    logic        rq;
    logic        rf;
    for (int i = 0; i < 32; i++) rv[i] = 0;

    repeat (2) cycle(1, 0, 16'h0000, 0);

    lat = 4;
    repeat (14) cycle(0, 1, 16'h0124, 0);
    check("first_fill_count", miss_count, 1);
    for (int k = 0; k < 8; k++) cycle(0, 1, 16'h0120 + 16'(2 * k), 0);
    check("seq_hits_count", miss_count, 1);

    repeat (14) cycle(0, 1, 16'h0324, 0);
    repeat (14) cycle(0, 1, 16'h0124, 0);
    check("conflict_count", miss_count, 3);

    cycle(0, 0, 16'h0000, 1);
    repeat (14) cycle(0, 1, 16'h0124, 0);

    repeat (5) cycle(0, 1, 16'h0124, 0);
    cycle(1, 0, 16'h0124, 0);
    repeat (15) cycle(0, 0, 16'h0000, 0);
    repeat (14) cycle(0, 1, 16'h0124, 0);
    check("post_reset_count", miss_count, 1);

    lat = 1;
    cycle(0, 0, 16'h0000, 1);
    repeat (4) cycle(0, 1, 16'h0124, 0);
    repeat (20) cycle(0, 1, 16'h0500, 0);
    cycle(0, 1, 16'h0124, 0);
    check("addr_change_count", miss_count, 3);

    for (int seg = 0; seg < 6; seg++) begin
      lat = int'($urandom_range(1, 6));
      repeat (300) begin
        rq = ($urandom % 8) != 0;
        rf = ($urandom % 40) == 0;
        ra = 16'(($urandom % 4) << 9) | 16'(($urandom % 4) << 4) | 16'($urandom % 16);
        cycle(0, rq, ra, rf);
      end
      repeat (20) cycle(0, 0, 16'h0000, 0);
      check("mem_queue_drained", q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
